// File: rtl/loop_bank_scheduler.sv
// Per-sample time-division scheduler between the looper banks and the DDR RAM port.
// Each sample pulse sweeps every bank once (clear / record / read / skip), then advances the shared loop block address.
module loop_bank_scheduler #(
  parameter int NUM_BANKS  = 16,
  parameter int BLOCK_W    = 22,
  parameter int WR_CYCLES  = 60,
  parameter int RD_TIMEOUT = 255,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_pulse,
  input  logic [NUM_BANKS-1:0] playing,
  input  logic [NUM_BANKS-1:0] recording,
  input  logic [NUM_BANKS-1:0] clear,
  input  logic [BLOCK_W-1:0]   loop_len,
  input  logic                 rd_valid,
  input  logic                 status_clr,
  output logic                 ram_cen,
  output logic                 ram_oen,
  output logic                 ram_wen,
  output logic                 write_zero,
  output logic                 get_data,
  output logic                 data_ready,
  output logic                 data_is_read,
  output logic [BANK_W-1:0]    bank,
  output logic [BLOCK_W-1:0]   block_addr,
  output logic [NUM_BANKS-1:0] active,
  output logic                 overrun,
  output logic                 rd_timeout
);

  // state  | meaning
  // IDLE   | waiting for sample_pulse
  // SELECT | decode the mode of the current bank
  // WRITE  | write strobes held for WR_CYCLES cycles
  // READ   | waiting for rd_valid or the read timeout
  // REPORT | data_ready pulse for the current bank
  // ADV    | advance block address, return to bank 0
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    REPORT = 3'd4,
    ADV    = 3'd5
  } state_t;

  localparam int CNT_MAX = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(RD_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BANK_W-1:0]    bank_nxt;
  logic [BLOCK_W-1:0]   block_nxt, blk_last;
  logic [NUM_BANKS-1:0] active_nxt;
  logic                 cen_nxt, oen_nxt, wen_nxt;
  logic                 wz_nxt, gd_nxt, dr_nxt, dir_nxt;
  logic                 ovr_set, tmo_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bank         <= '0;
      block_addr   <= '0;
      active       <= '0;
      ram_cen      <= 1'b1;
      ram_oen      <= 1'b1;
      ram_wen      <= 1'b1;
      write_zero   <= 1'b0;
      get_data     <= 1'b0;
      data_ready   <= 1'b0;
      data_is_read <= 1'b0;
      overrun      <= 1'b0;
      rd_timeout   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bank         <= bank_nxt;
      block_addr   <= block_nxt;
      active       <= active_nxt;
      ram_cen      <= cen_nxt;
      ram_oen      <= oen_nxt;
      ram_wen      <= wen_nxt;
      write_zero   <= wz_nxt;
      get_data     <= gd_nxt;
      data_ready   <= dr_nxt;
      data_is_read <= dir_nxt;
      // a new event in the same cycle as status_clr keeps the flag set
      overrun      <= ovr_set | (overrun & ~status_clr);
      rd_timeout   <= tmo_set | (rd_timeout & ~status_clr);
    end
  end

  // loop_len of 0 behaves as a one-block loop
  assign blk_last = (loop_len == '0) ? '0 : loop_len - BLOCK_W'(1);
  assign ovr_set  = sample_pulse && (state != IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bank_nxt   = bank;
    block_nxt  = block_addr;
    active_nxt = active;
    cen_nxt    = 1'b1;
    oen_nxt    = 1'b1;
    wen_nxt    = 1'b1;
    wz_nxt     = 1'b0;
    gd_nxt     = 1'b0;
    dr_nxt     = 1'b0;
    dir_nxt    = 1'b0;
    tmo_set    = 1'b0;

    case (state)
      IDLE: begin
        if (sample_pulse) begin
          state_nxt = SELECT;
          bank_nxt  = '0;
        end
      end

      SELECT: begin
        if (clear[bank]) begin
          state_nxt = WRITE;
          cnt_nxt   = WR_LOAD;
          cen_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          wz_nxt    = 1'b1;
        end else if (recording[bank]) begin
          state_nxt = WRITE;
          cnt_nxt   = WR_LOAD;
          cen_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          gd_nxt    = 1'b1;
        end else if (playing[bank]) begin
          state_nxt = READ;
          cnt_nxt   = RD_LOAD;
          cen_nxt   = 1'b0;
          oen_nxt   = 1'b0;
        end else begin
          state_nxt = REPORT;
          dr_nxt    = 1'b1;
        end
      end

      WRITE: begin
        if (cnt == '0) begin
          state_nxt        = REPORT;
          dr_nxt           = 1'b1;
          active_nxt[bank] = ~write_zero;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          cen_nxt = 1'b0;
          wen_nxt = 1'b0;
          wz_nxt  = write_zero;
        end
      end

      READ: begin
        // valid data wins over a timeout expiring in the same cycle
        if (rd_valid) begin
          state_nxt = REPORT;
          dr_nxt    = 1'b1;
          dir_nxt   = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = REPORT;
          dr_nxt    = 1'b1;
          tmo_set   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          cen_nxt = 1'b0;
          oen_nxt = 1'b0;
        end
      end

      REPORT: begin
        if (bank == LAST_BANK) begin
          state_nxt = ADV;
        end else begin
          state_nxt = SELECT;
          bank_nxt  = bank + BANK_W'(1);
        end
      end

      ADV: begin
        if ((playing | recording | clear) == '0) begin
          block_nxt = '0;
        end else if (block_addr >= blk_last) begin
          block_nxt = '0;
        end else begin
          block_nxt = block_addr + BLOCK_W'(1);
        end
        bank_nxt  = '0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        bank_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_loop_bank_scheduler.sv
// Bench for loop_bank_scheduler: each sweep is predicted as a per-cycle timeline of slot durations
// and strobes, plus end-of-sweep active / block_addr / flag state.
module tb_loop_bank_scheduler;
  localparam int NB   = 4;
  localparam int BW   = 8;
  localparam int WR   = 4;
  localparam int TO   = 8;
  localparam int MAXT = 64;
  localparam int BKW  = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_pulse;
  logic [NB-1:0] playing, recording, clear;
  logic [BW-1:0] loop_len;
  logic          rd_valid, status_clr;
  logic          ram_cen, ram_oen, ram_wen, write_zero, get_data, data_ready, data_is_read;
  logic [BKW-1:0] bank;
  logic [BW-1:0] block_addr;
  logic [NB-1:0] active;
  logic          overrun, rd_timeout;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0]   m_active;
  int              m_block;
  logic            m_tmo, m_ovr;
  int              rdk [NB];
  logic [MAXT-1:0] e_cen, e_oen, e_wen, e_gd, e_wz, e_dr, e_dir, e_rdv;
  int              e_bank [MAXT];
  int              t_end;

  loop_bank_scheduler #(
    .NUM_BANKS(NB), .BLOCK_W(BW), .WR_CYCLES(WR), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .sample_pulse(sample_pulse),
    .playing(playing), .recording(recording), .clear(clear),
    .loop_len(loop_len), .rd_valid(rd_valid), .status_clr(status_clr),
    .ram_cen(ram_cen), .ram_oen(ram_oen), .ram_wen(ram_wen),
    .write_zero(write_zero), .get_data(get_data), .data_ready(data_ready),
    .data_is_read(data_is_read), .bank(bank), .block_addr(block_addr),
    .active(active), .overrun(overrun), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Predict one sweep as a timeline: cycle 0 = pulse, cycle 1 = first SELECT.
  task automatic build_timeline(input logic [NB-1:0] pl, input logic [NB-1:0] rec,
                                input logic [NB-1:0] clr);
    int t, r, n, len;
    e_cen = '1; e_oen = '1; e_wen = '1;
    e_gd = '0; e_wz = '0; e_dr = '0; e_dir = '0; e_rdv = '0;
    for (int i = 0; i < MAXT; i++) e_bank[i] = 0;
    t = 1;
    for (int b = 0; b < NB; b++) begin
      if (clr[b] || rec[b]) begin
        for (int i = 1; i <= WR; i++) begin
          e_cen[t+i] = 1'b0;
          e_wen[t+i] = 1'b0;
          e_wz[t+i]  = clr[b];
        end
        e_gd[t+1]   = !clr[b];
        m_active[b] = !clr[b];
        r = t + WR + 1;
      end else if (pl[b]) begin
        if (rdk[b] >= 1 && rdk[b] <= TO) begin
          n = rdk[b];
          e_rdv[t+n]   = 1'b1;
          e_dir[t+n+1] = 1'b1;
        end else begin
          n = TO;
          m_tmo = 1'b1;
        end
        for (int i = 1; i <= n; i++) begin
          e_cen[t+i] = 1'b0;
          e_oen[t+i] = 1'b0;
        end
        r = t + n + 1;
      end else begin
        r = t + 1;
      end
      e_dr[r]   = 1'b1;
      e_bank[r] = b;
      t = r + 1;
    end
    t_end = t + 1;
    len = (loop_len == 0) ? 1 : int'(loop_len);
    if ((pl | rec | clr) == '0) m_block = 0;
    else if (m_block + 1 >= len) m_block = 0;
    else m_block = m_block + 1;
  endtask

  task automatic run_sweep(input logic [NB-1:0] pl, input logic [NB-1:0] rec,
                           input logic [NB-1:0] clr, input int ovr_at, input string tag);
    logic [6:0] got, exp;
    playing = pl; recording = rec; clear = clr;
    build_timeline(pl, rec, clr);
    if (ovr_at > 0) m_ovr = 1'b1;
    for (int c = 0; c <= t_end + 2; c++) begin
      @(posedge clk); #1;
      sample_pulse = (c == 0) || (ovr_at > 0 && c == ovr_at);
      rd_valid     = e_rdv[c];
      @(negedge clk);
      got = {ram_cen, ram_oen, ram_wen, get_data, write_zero, data_ready, data_is_read};
      exp = {e_cen[c], e_oen[c], e_wen[c], e_gd[c], e_wz[c], e_dr[c], e_dir[c]};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s strobes cycle=%0d got=%b exp=%b (cen oen wen gd wz dr dir)", tag, c, got, exp);
      end
      if (e_dr[c]) begin
        total++;
        if (int'(bank) !== e_bank[c]) begin
          bad++;
          $display("FAIL %s bank cycle=%0d got=%0d exp=%0d", tag, c, bank, e_bank[c]);
        end
      end
    end
    sample_pulse = 1'b0;
    rd_valid     = 1'b0;
    total++;
    if (int'(block_addr) !== m_block) begin
      bad++;
      $display("FAIL %s block_addr got=%0d exp=%0d", tag, block_addr, m_block);
    end
    total++;
    if (active !== m_active) begin
      bad++;
      $display("FAIL %s active got=%b exp=%b", tag, active, m_active);
    end
    total++;
    if ({overrun, rd_timeout} !== {m_ovr, m_tmo}) begin
      bad++;
      $display("FAIL %s flags got=%b exp=%b (overrun rd_timeout)", tag, {overrun, rd_timeout}, {m_ovr, m_tmo});
    end
  endtask

  task automatic pulse_status_clr(input string tag);
    @(posedge clk); #1; status_clr = 1'b1;
    @(posedge clk); #1; status_clr = 1'b0;
    m_tmo = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    total++;
    if ({overrun, rd_timeout} !== 2'b00) begin
      bad++;
      $display("FAIL %s status_clr got=%b exp=00", tag, {overrun, rd_timeout});
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [8:0] got;
    got = {ram_cen, ram_oen, ram_wen, write_zero, get_data, data_ready, data_is_read, overrun, rd_timeout};
    total++;
    if (got !== 9'b111_000000) begin
      bad++;
      $display("FAIL %s outputs got=%b exp=111000000", tag, got);
    end
    total++;
    if ({bank, block_addr, active} !== '0) begin
      bad++;
      $display("FAIL %s bank/block/active got=%0d/%0d/%b exp=0/0/0", tag, bank, block_addr, active);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; sample_pulse = 1'b0; rd_valid = 1'b0; status_clr = 1'b0;
    playing = '0; recording = '0; clear = '0; loop_len = '0;
    for (int b = 0; b < NB; b++) rdk[b] = 0;
    m_active = '0; m_block = 0; m_tmo = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
  endtask

  task automatic test_skip_sweep;
    run_sweep(4'b0000, 4'b0000, 4'b0000, 0, "skip");
  endtask

  task automatic test_record;
    int seq [4];
    seq[0] = 1; seq[1] = 2; seq[2] = 0; seq[3] = 1;
    loop_len = 8'd3;
    for (int i = 0; i < 4; i++) begin
      run_sweep(4'b0000, 4'b0010, 4'b0000, 0, "record");
      total++;
      if (int'(block_addr) !== seq[i]) begin
        bad++;
        $display("FAIL record_seq pulse=%0d got=%0d exp=%0d", i, block_addr, seq[i]);
      end
    end
    total++;
    if (active !== 4'b0010) begin
      bad++;
      $display("FAIL record_active got=%b exp=0010", active);
    end
  endtask

  task automatic test_read_valid;
    rdk[0] = 5;
    run_sweep(4'b0001, 4'b0000, 4'b0000, 0, "read_valid");
  endtask

  task automatic test_read_timeout;
    rdk[0] = 0;
    run_sweep(4'b0001, 4'b0000, 4'b0000, 0, "read_timeout");
    total++;
    if (rd_timeout !== 1'b1) begin
      bad++;
      $display("FAIL read_timeout flag got=%b exp=1", rd_timeout);
    end
    pulse_status_clr("read_timeout");
  endtask

  task automatic test_clear;
    run_sweep(4'b0000, 4'b0100, 4'b0000, 0, "clear_prep");
    total++;
    if (active[2] !== 1'b1) begin
      bad++;
      $display("FAIL clear_prep active2 got=%b exp=1", active[2]);
    end
    run_sweep(4'b0000, 4'b0100, 4'b0100, 0, "clear");
    total++;
    if (active[2] !== 1'b0) begin
      bad++;
      $display("FAIL clear active2 got=%b exp=0", active[2]);
    end
  endtask

  task automatic test_overrun;
    run_sweep(4'b0000, 4'b0001, 4'b0000, 3, "overrun");
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun flag got=%b exp=1", overrun);
    end
    pulse_status_clr("overrun");
  endtask

  task automatic test_random;
    logic [NB-1:0] pl, rec, clr;
    for (int s = 0; s < 10; s++) begin
      pl  = NB'($urandom_range(0, 15));
      rec = NB'($urandom_range(0, 15));
      clr = NB'($urandom & $urandom & 15);
      for (int b = 0; b < NB; b++) rdk[b] = $urandom_range(0, TO);
      loop_len = BW'($urandom_range(0, 5));
      run_sweep(pl, rec, clr, 0, "random");
    end
  endtask

  task automatic test_reset_mid_write;
    logic seen_dr;
    playing = '0; recording = 4'b0001; clear = '0;
    @(posedge clk); #1; sample_pulse = 1'b1;
    @(posedge clk); #1; sample_pulse = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({ram_cen, ram_wen} !== 2'b00) begin
      bad++;
      $display("FAIL midwrite_pre strobes got=%b exp=00", {ram_cen, ram_wen});
    end
    #1 rst = 1'b0;
    #1;
    check_reset_values("midwrite_reset");
    m_active = '0; m_block = 0; m_tmo = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen_dr = 1'b0;
    for (int i = 0; i < WR + 4; i++) begin
      @(negedge clk);
      if (data_ready) seen_dr = 1'b1;
    end
    total++;
    if (seen_dr !== 1'b0) begin
      bad++;
      $display("FAIL midwrite_no_report got=%b exp=0", seen_dr);
    end
    recording = '0;
  endtask

  initial begin
    test_reset();
    test_skip_sweep();
    test_record();
    test_read_valid();
    test_read_timeout();
    test_clear();
    test_overrun();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loop_bank_scheduler.md
Name: loop_bank_scheduler

Overview:
- Per-sample time-division scheduler between the audio looper banks and the DDR RAM port. It is the parametrised successor of the fixed 16-bank memory interface.
- On each sample pulse it visits every bank once and performs one action per bank: write the latched sample, write zero (clear), read back, or skip.
- After the last bank it advances a shared block address that wraps at a runtime loop length.
- It adds per-bank clear, per-bank recorded flags, read timeout and overrun detection. It sits between mem_ctrl-level control and DDRcontrol.

Parameters:
- NUM_BANKS, 16, number of looper banks (2..64); BANK_W = clog2(NUM_BANKS), local.
- BLOCK_W, 22, block address width.
- WR_CYCLES, 60, cycles RAM strobes are held for a write (>=2).
- RD_TIMEOUT, 255, cycles to wait for rd_valid before abandoning a read (>=1).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- sample_pulse  in  1  one-cycle 48 kHz frame strobe.
- playing  in  NUM_BANKS  bank read-back enable.
- recording  in  NUM_BANKS  bank record enable.
- clear  in  NUM_BANKS  bank clear (write-zero) enable.
- loop_len  in  BLOCK_W  number of blocks in the loop; 0 is treated as 1.
- rd_valid  in  1  single-cycle read-data-valid from the RAM controller (already edge-detected).
- status_clr  in  1  pulse; clears overrun and rd_timeout.
- ram_cen  out  1  chip enable, active-low.
- ram_oen  out  1  output enable, active-low.
- ram_wen  out  1  write enable, active-low.
- write_zero  out  1  selects a zero data word during a clear write.
- get_data  out  1  one-cycle pulse that latches the input sample for a record write.
- data_ready  out  1  one-cycle pulse: the current bank's slot is complete.
- data_is_read  out  1  qualifies data_ready; 1 means read data is valid for this bank.
- bank  out  BANK_W  bank currently being serviced.
- block_addr  out  BLOCK_W  current block address.
- active  out  NUM_BANKS  bank holds recorded material.
- overrun  out  1  sticky: a sample_pulse arrived while busy.
- rd_timeout  out  1  sticky: a read timed out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bank=0; block_addr=0; active=0.
  - ram_cen=ram_oen=ram_wen=1.
  - write_zero, get_data, data_ready, data_is_read, overrun and rd_timeout all 0.
  - Reset mid-operation aborts the slot immediately; no data_ready is issued.
- All outputs are registered.
- States: IDLE, SELECT, WRITE, READ, REPORT, ADV.
- IDLE: sample_pulse=1 -> SELECT with bank=0.
- SELECT (1 cycle): decode mode of bank, priority clear > recording > playing > skip.
  - Clear: ->WRITE with write_zero=1.
  - Record: ->WRITE with get_data=1 for the first WRITE cycle only.
  - WRITE outputs: cen=0, oen=1, wen=0.
  - Play: ->READ with cen=0, oen=0, wen=1.
  - Skip: ->REPORT with no strobes.
- WRITE: hold strobes for exactly WR_CYCLES cycles, then ->REPORT.
  - Set active[bank]=1 on a record write; clear active[bank]=0 on a clear write.
- READ:
  - rd_valid=1 -> REPORT with data_is_read=1.
  - RD_TIMEOUT cycles without rd_valid -> REPORT with data_is_read=0 and rd_timeout set.
  - rd_valid arriving in the same cycle as the timeout counts as valid.
- REPORT (1 cycle): data_ready=1; cen=oen=wen=1; write_zero=0.
  - bank==NUM_BANKS-1 -> ADV.
  - Otherwise bank+1 -> SELECT.
- ADV (1 cycle):
  - If (playing|recording|clear)==0, block_addr=0.
  - Else if block_addr >= max(loop_len,1)-1, block_addr=0.
  - Else block_addr+1.
  - Then bank=0 -> IDLE.
- Timing:
  - Skip slot = 2 cycles; write slot = WR_CYCLES+2; read slot = 2 + wait.
  - First SELECT is the cycle after sample_pulse.
- Overrun: sample_pulse while state != IDLE sets overrun and the pulse is dropped; the sweep continues.
- Status clear: status_clr clears the flags; a set event in the same cycle as status_clr wins.
- Mode sampling: playing, recording and clear are sampled only in SELECT; changes mid-slot take effect at the next visit of that bank.
- loop_len changes take effect at the next ADV. If the new loop_len is at or below the current address, the address wraps to 0.

Test Plan:
- NUM_BANKS=4, all enables 0, pulse at cycle 0:
  - data_ready at cycles 2, 4, 6, 8 with bank 0..3 and no RAM strobes.
  - block_addr stays 0; back in IDLE at cycle 10.
- recording=4'b0010, WR_CYCLES=4, loop_len=3, 4 pulses:
  - bank 1 gets get_data for 1 cycle, then wen/cen low for 4 cycles, then data_ready.
  - active=4'b0010.
  - block_addr sequence after each pulse: 1, 2, 0, 1.
- playing=4'b0001, rd_valid 5 cycles after SELECT: data_ready with data_is_read=1 and bank=0, with oen held low until then.
- playing=4'b0001, rd_valid never, RD_TIMEOUT=8:
  - REPORT after 8 READ cycles with data_is_read=0 and rd_timeout=1.
  - status_clr -> rd_timeout=0.
- clear=recording=4'b0100 with active[2]=1: write_zero=1, get_data=0 for the bank 2 slot; active[2] -> 0.
- Second pulse during the sweep sets overrun=1 and no extra sweep runs; rst low mid-WRITE returns all outputs to reset values within the same cycle.
